// File: rtl/dlfloat_operand_loader_if.sv
`timescale 1ns/1ps
// Byte-stream input and MAC-side pair handshake for the DLFloat16 operand loader.
// master: upstream byte source / downstream MAC side; slave: the loader itself.
interface dlfloat_operand_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_valid;
    logic        mac_ready;
    logic        acc_clr;

    modport master (
        output byte_in, byte_valid, mac_ready,
        input  byte_ready, mac_a, mac_b, mac_valid, acc_clr
    );

    modport slave (
        input  byte_in, byte_valid, mac_ready,
        output byte_ready, mac_a, mac_b, mac_valid, acc_clr
    );
endinterface

// File: rtl/dlfloat_operand_loader.sv
`timescale 1ns/1ps
// DLFloat16 operand loader: assembles little-endian byte stream into (a,b)
// pairs, buffers them in a first-word-fall-through FIFO, optionally drops
// zero-product pairs, and supports a synchronous flush with accumulator clear.
module dlfloat_operand_loader #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SKIP_ZERO = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dlfloat_operand_loader_if.slave    io,
    input  logic                       seq_clr,
    output logic [AW:0]                fifo_level,
    output logic [15:0]                pair_cnt,
    output logic [7:0]                 drop_cnt
);

    typedef enum logic [1:0] {
        A_LO = 2'd0,
        A_HI = 2'd1,
        B_LO = 2'd2,
        B_HI = 2'd3
    } state_t;

    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    state_t         state;
    state_t         state_next;

    logic [7:0]     a_lo;
    logic [7:0]     a_hi;
    logic [7:0]     b_lo;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic           full;
    logic           ready;
    logic           accept;
    logic           push;
    logic           drop;
    logic           pop;
    logic           head_valid;
    logic [15:0]    pair_a;
    logic [15:0]    pair_b;
    logic           pair_zero;

    // Next-state, handshake and push/drop/pop decisions from registered state.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        drop       = 1'b0;
        full       = (fifo_level == LEVEL_FULL);
        head_valid = (fifo_level != '0);
        ready      = !((state == B_HI) && full);
        accept     = io.byte_valid && ready;
        pair_a     = {a_hi, a_lo};
        pair_b     = {io.byte_in, b_lo};
        pair_zero  = (SKIP_ZERO != 0) && ((pair_a == '0) || (pair_b == '0));
        pop        = head_valid && io.mac_ready && !seq_clr;

        if (seq_clr) begin
            state_next = A_LO;
        end else if (accept) begin
            case (state)
                A_LO:    state_next = A_HI;
                A_HI:    state_next = B_LO;
                B_LO:    state_next = B_HI;
                B_HI: begin
                    state_next = A_LO;
                    if (pair_zero) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                default: state_next = A_LO;
            endcase
        end
    end

    // Assembly state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= A_LO;
        end else begin
            state <= state_next;
        end
    end

    // Partial-byte holding registers; a flush discards them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lo <= '0;
            a_hi <= '0;
            b_lo <= '0;
        end else if (seq_clr) begin
            a_lo <= '0;
            a_hi <= '0;
            b_lo <= '0;
        end else if (accept) begin
            case (state)
                A_LO:    a_lo <= io.byte_in;
                A_HI:    a_hi <= io.byte_in;
                B_LO:    b_lo <= io.byte_in;
                default: ;
            endcase
        end
    end

    // FIFO storage, pointers and occupancy; simultaneous push/pop keeps level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (seq_clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {pair_a, pair_b};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
        end
    end

    // Issue/drop statistics and the one-cycle accumulator clear after a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt   <= '0;
            drop_cnt   <= '0;
            io.acc_clr <= 1'b0;
        end else begin
            io.acc_clr <= seq_clr;
            if (seq_clr) begin
                pair_cnt <= '0;
                drop_cnt <= '0;
            end else begin
                if (pop) begin
                    pair_cnt <= pair_cnt + 1'b1;
                end
                if (drop && (drop_cnt != '1)) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    // Head-of-FIFO presentation; data forced to zero while empty.
    always_comb begin
        io.byte_ready = ready;
        io.mac_valid  = head_valid;
        io.mac_a      = '0;
        io.mac_b      = '0;
        if (head_valid) begin
            io.mac_a = mem[rd_ptr][31:16];
            io.mac_b = mem[rd_ptr][15:0];
        end
    end

endmodule
